// File: rtl/wb_stage.sv
// Writeback stage: selects the rd source, extends/aligns load data, and waits for the memory response.
// Optional macro WB_RETIRE_CNT_EN adds a 64-bit retired-instruction counter output.
module wb_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_wb_sel,
  input  logic            in_rd_we,
  input  logic [4:0]      in_rd,
  input  logic            in_is_load,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_addr_lo,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            wb_stall,
  output logic            misalign_err
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]     retire_count
`endif
);

  typedef enum logic {
    S_IDLE,
    S_WAIT_LOAD
  } state_t;

  state_t r_state;

  logic       r_rd_we;
  logic [4:0] r_rd;
  logic [2:0] r_funct3;
  logic [1:0] r_addr_lo;

  logic            w_idle;
  logic            w_accept;
  logic            w_ld_done;
  logic            w_ld_rd_we;
  logic [4:0]      w_ld_rd;
  logic [2:0]      w_ld_funct3;
  logic [1:0]      w_ld_addr_lo;
  logic [XLEN-1:0] w_ld_shift;
  logic [XLEN-1:0] w_ld_data;
  logic            w_ld_bad;
  logic            w_ld_write;
  logic            w_nl_write;
  logic [XLEN-1:0] w_nl_data;

  assign w_idle   = (r_state == S_IDLE);
  assign in_ready = w_idle;
  assign w_accept = in_valid & w_idle;
  assign wb_stall = (r_state == S_WAIT_LOAD) | (w_idle & in_valid & in_is_load & ~mem_rsp_valid);

  // A load completes either from the captured fields (WAIT_LOAD) or straight from the inputs
  // when the response arrives in the accept cycle.
  assign w_ld_done    = mem_rsp_valid & ((r_state == S_WAIT_LOAD) | (w_accept & in_is_load));
  assign w_ld_rd_we   = w_idle ? in_rd_we   : r_rd_we;
  assign w_ld_rd      = w_idle ? in_rd      : r_rd;
  assign w_ld_funct3  = w_idle ? in_funct3  : r_funct3;
  assign w_ld_addr_lo = w_idle ? in_addr_lo : r_addr_lo;

  assign w_ld_shift = mem_rsp_data >> {w_ld_addr_lo, 3'b000};

  always_comb begin
    w_ld_data = '0;
    w_ld_bad  = 1'b0;
    unique case (w_ld_funct3)
      3'b000: w_ld_data = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
      3'b100: w_ld_data = {24'd0, w_ld_shift[7:0]};
      3'b001: begin
        w_ld_data = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
        w_ld_bad  = w_ld_addr_lo[0];
      end
      3'b101: begin
        w_ld_data = {16'd0, w_ld_shift[15:0]};
        w_ld_bad  = w_ld_addr_lo[0];
      end
      3'b010: begin
        w_ld_data = w_ld_shift;
        w_ld_bad  = (w_ld_addr_lo != 2'd0);
      end
      default: w_ld_bad = 1'b1;
    endcase
  end

  // Loads that do not target a real register neither write nor report an error.
  assign w_ld_write = w_ld_rd_we & (w_ld_rd != 5'd0);

  assign w_nl_write = w_accept & ~in_is_load & in_rd_we & (in_rd != 5'd0) & (in_wb_sel != 2'b11);

  always_comb begin
    w_nl_data = '0;
    unique case (in_wb_sel)
      2'b01:   w_nl_data = in_alu_result;
      2'b10:   w_nl_data = in_pc_plus4;
      default: w_nl_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rd_we      <= 1'b0;
      r_rd         <= '0;
      r_funct3     <= '0;
      r_addr_lo    <= '0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      misalign_err <= 1'b0;
    end else begin
      rf_we        <= 1'b0;
      misalign_err <= 1'b0;

      if (w_ld_done) begin
        if (w_ld_write && !w_ld_bad) begin
          rf_we    <= 1'b1;
          rf_waddr <= w_ld_rd;
          rf_wdata <= w_ld_data;
        end else if (w_ld_write) begin
          misalign_err <= 1'b1;
        end
      end else if (w_nl_write) begin
        rf_we    <= 1'b1;
        rf_waddr <= in_rd;
        rf_wdata <= w_nl_data;
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_accept && in_is_load && !mem_rsp_valid) begin
            r_rd_we   <= in_rd_we;
            r_rd      <= in_rd;
            r_funct3  <= in_funct3;
            r_addr_lo <= in_addr_lo;
            r_state   <= S_WAIT_LOAD;
          end
        end
        S_WAIT_LOAD: begin
          if (mem_rsp_valid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_count <= '0;
    end else if (w_ld_done || (w_accept && !in_is_load)) begin
      retire_count <= retire_count + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic against a reference model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_wb_sel;
  logic        in_rd_we;
  logic [4:0]  in_rd;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_stall;
  logic        misalign_err;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_count;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [63:0] m_cnt;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_wb_sel(in_wb_sel), .in_rd_we(in_rd_we), .in_rd(in_rd), .in_is_load(in_is_load),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .in_alu_result(in_alu_result),
    .in_pc_plus4(in_pc_plus4), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_stall(wb_stall),
    .misalign_err(misalign_err)
`ifdef WB_RETIRE_CNT_EN
    , .retire_count(retire_count)
`endif
  );

  // Reference: extract the addressed byte/halfword arithmetically and extend by value range.
  function automatic logic [31:0] ld_val(input logic [31:0] d, input logic [2:0] f3, input logic [1:0] a);
    int unsigned s, b, h;
    s = d / (32'd1 << (8 * int'(a)));
    b = s % 256;
    h = s % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      3'd2:    return s;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ld_bad(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return (a % 2) != 0;
      3'd2:       return a != 0;
      default:    return 1'b1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_valid = 0; in_wb_sel = 0; in_rd_we = 0; in_rd = 0; in_is_load = 0;
    in_funct3 = 0; in_addr_lo = 0; in_alu_result = 0; in_pc_plus4 = 0;
    mem_rsp_valid = 0; mem_rsp_data = 0;
  endtask

  task automatic drive_nl(input logic [1:0] sel, input logic we, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] pc4);
    in_valid = 1; in_is_load = 0; in_wb_sel = sel; in_rd_we = we; in_rd = rd;
    in_alu_result = alu; in_pc_plus4 = pc4; in_funct3 = 0; in_addr_lo = 0;
  endtask

  task automatic drive_ld(input logic [2:0] f3, input logic [1:0] a, input logic we, input logic [4:0] rd);
    in_valid = 1; in_is_load = 1; in_wb_sel = 2'b00; in_rd_we = we; in_rd = rd;
    in_funct3 = f3; in_addr_lo = a; in_alu_result = $urandom; in_pc_plus4 = $urandom;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1;
    #12;
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got %0h want 0", rf_we); end
    n_cmp++; if (rf_waddr !== 5'd0) begin n_bad++; $display("FAIL reset_waddr got %0h want 0", rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'd0) begin n_bad++; $display("FAIL reset_wdata got %0h want 0", rf_wdata); end
    n_cmp++; if (misalign_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %0h want 0", misalign_err); end
    n_cmp++; if (in_ready !== 1'b1 || wb_stall !== 1'b0) begin n_bad++; $display("FAIL reset_ready_stall got %0h/%0h want 1/0", in_ready, wb_stall); end
    @(negedge clk);
    rst = 0;
    m_waddr = 0; m_wdata = 0; m_cnt = 0;
    tick();
  endtask

  task automatic test_alu();
    drive_nl(2'b01, 1'b1, 5'd5, 32'h1234_5678, 32'h0);
    tick();
    drive_idle();
    m_cnt++; m_waddr = 5; m_wdata = 32'h1234_5678;
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5) begin n_bad++; $display("FAIL alu_we_addr got %0h/%0d want 1/5", rf_we, rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'h1234_5678) begin n_bad++; $display("FAIL alu_wdata got %0h want 12345678", rf_wdata); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL alu_ready got %0h want 1", in_ready); end
    tick();
    n_cmp++; if (rf_we !== 1'b0 || rf_wdata !== m_wdata) begin n_bad++; $display("FAIL alu_hold got %0h/%0h want 0/%0h", rf_we, rf_wdata, m_wdata); end
  endtask

  task automatic test_jal();
    drive_nl(2'b10, 1'b1, 5'd1, 32'hDEAD_0000, 32'h0000_0104);
    tick();
    m_cnt++; m_waddr = 1; m_wdata = 32'h104;
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'h104) begin n_bad++; $display("FAIL jal got %0h/%0d/%0h want 1/1/104", rf_we, rf_waddr, rf_wdata); end
    drive_nl(2'b10, 1'b1, 5'd0, 32'h0, 32'h0000_0200);
    tick();
    drive_idle();
    m_cnt++;
    n_cmp++; if (rf_we !== 1'b0 || rf_wdata !== m_wdata) begin n_bad++; $display("FAIL jal_rd0 got %0h/%0h want 0/%0h", rf_we, rf_wdata, m_wdata); end
  endtask

  task automatic test_reserved();
    drive_nl(2'b11, 1'b1, 5'd3, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
    tick();
    drive_idle();
    m_cnt++;
    n_cmp++; if (rf_we !== 1'b0 || rf_waddr !== m_waddr) begin n_bad++; $display("FAIL reserved_sel got %0h/%0d want 0/%0d", rf_we, rf_waddr, m_waddr); end
  endtask

  task automatic test_delayed_lb();
    drive_ld(3'b000, 2'd2, 1'b1, 5'd7);
    #1;
    n_cmp++; if (wb_stall !== 1'b1) begin n_bad++; $display("FAIL lb_accept_stall got %0h want 1", wb_stall); end
    tick();
    // Upstream keeps something valid while waiting; it must be ignored.
    drive_nl(2'b01, 1'b1, 5'd9, 32'h5555_5555, 32'h0);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (in_ready !== 1'b0 || wb_stall !== 1'b1 || rf_we !== 1'b0) begin n_bad++; $display("FAIL lb_wait%0d got rdy=%0h stall=%0h we=%0h want 0/1/0", k, in_ready, wb_stall, rf_we); end
      tick();
    end
    mem_rsp_valid = 1; mem_rsp_data = 32'h00F0_0000;
    tick();
    drive_idle();
    m_cnt++; m_waddr = 7; m_wdata = 32'hFFFF_FFF0;
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hFFFF_FFF0) begin n_bad++; $display("FAIL lb_result got %0h/%0d/%0h want 1/7/fffffff0", rf_we, rf_waddr, rf_wdata); end
    n_cmp++; if (in_ready !== 1'b1 || wb_stall !== 1'b0) begin n_bad++; $display("FAIL lb_idle got %0h/%0h want 1/0", in_ready, wb_stall); end
  endtask

  task automatic test_same_cycle();
    drive_ld(3'b101, 2'd2, 1'b1, 5'd10);
    mem_rsp_valid = 1; mem_rsp_data = 32'hBEEF_0000;
    #1;
    n_cmp++; if (wb_stall !== 1'b0) begin n_bad++; $display("FAIL lhu_stall got %0h want 0", wb_stall); end
    tick();
    m_cnt++; m_waddr = 10; m_wdata = 32'h0000_BEEF;
    n_cmp++; if (rf_we !== 1'b1 || rf_wdata !== 32'h0000_BEEF || in_ready !== 1'b1) begin n_bad++; $display("FAIL lhu got %0h/%0h/%0h want 1/beef/1", rf_we, rf_wdata, in_ready); end
    drive_ld(3'b010, 2'd0, 1'b1, 5'd11);
    mem_rsp_valid = 1; mem_rsp_data = 32'hDEAD_BEEF;
    tick();
    drive_idle();
    m_cnt++; m_waddr = 11; m_wdata = 32'hDEAD_BEEF;
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw got %0h/%0d/%0h want 1/11/deadbeef", rf_we, rf_waddr, rf_wdata); end
  endtask

  task automatic test_misalign();
    drive_ld(3'b010, 2'd1, 1'b1, 5'd12);
    tick();
    drive_idle();
    mem_rsp_valid = 1; mem_rsp_data = 32'h0123_4567;
    tick();
    mem_rsp_valid = 0;
    m_cnt++;
    n_cmp++; if (rf_we !== 1'b0 || misalign_err !== 1'b1) begin n_bad++; $display("FAIL misalign got we=%0h err=%0h want 0/1", rf_we, misalign_err); end
    tick();
    n_cmp++; if (misalign_err !== 1'b0) begin n_bad++; $display("FAIL misalign_pulse got %0h want 0", misalign_err); end
  endtask

  task automatic test_reset_wait();
    drive_ld(3'b000, 2'd0, 1'b1, 5'd13);
    tick();
    drive_idle();
    tick();
    #2 rst = 1;
    #1;
    m_waddr = 0; m_wdata = 0; m_cnt = 0;
    n_cmp++; if (in_ready !== 1'b1 || wb_stall !== 1'b0 || rf_wdata !== 32'd0) begin n_bad++; $display("FAIL rst_wait got rdy=%0h stall=%0h wdata=%0h want 1/0/0", in_ready, wb_stall, rf_wdata); end
    @(negedge clk);
    rst = 0;
    mem_rsp_valid = 1; mem_rsp_data = 32'hFFFF_FFFF;
    tick();
    mem_rsp_valid = 0;
    n_cmp++; if (rf_we !== 1'b0 || misalign_err !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL late_rsp got we=%0h err=%0h rdy=%0h want 0/0/1", rf_we, misalign_err, in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    for (int i = 0; i < 6; i++) begin
      v = $urandom;
      drive_nl(2'b01, 1'b1, 5'(i + 16), v, 32'h0);
      tick();
      m_cnt++; m_waddr = 5'(i + 16); m_wdata = v;
      n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== m_waddr || rf_wdata !== v) begin n_bad++; $display("FAIL b2b%0d got %0h/%0d/%0h want 1/%0d/%0h", i, rf_we, rf_waddr, rf_wdata, m_waddr, v); end
    end
    drive_idle();
  endtask

  task automatic test_random();
    int unsigned kind, dly;
    logic [1:0] sel, a;
    logic [2:0] f3;
    logic we, xwe, xerr;
    logic [4:0] rd;
    logic [31:0] alu, pc4, dat;
    for (int i = 0; i < 250; i++) begin
      kind = $urandom_range(0, 3);
      we = 1'($urandom_range(0, 1));
      rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if (kind < 2) begin
        sel = 2'($urandom_range(0, 3)); alu = $urandom; pc4 = $urandom;
        drive_nl(sel, we, rd, alu, pc4);
        #1;
        n_cmp++; if (in_ready !== 1'b1 || wb_stall !== 1'b0) begin n_bad++; $display("FAIL rnd_nl_hs got %0h/%0h want 1/0", in_ready, wb_stall); end
        tick();
        drive_idle();
        m_cnt++;
        xwe = we && rd != 0 && sel != 3;
        xerr = 1'b0;
        if (xwe) begin
          m_waddr = rd;
          m_wdata = (sel == 1) ? alu : (sel == 2) ? pc4 : 32'd0;
        end
      end else if (kind == 2) begin
        f3 = 3'($urandom_range(0, 7)); a = 2'($urandom_range(0, 3)); dat = $urandom;
        dly = $urandom_range(0, 3);
        drive_ld(f3, a, we, rd);
        mem_rsp_valid = (dly == 0); mem_rsp_data = dat;
        #1;
        n_cmp++; if (wb_stall !== (dly != 0)) begin n_bad++; $display("FAIL rnd_ld_stall got %0h want %0h", wb_stall, dly != 0); end
        tick();
        if (dly != 0) begin
          drive_nl(2'b01, 1'b1, 5'd30, $urandom, $urandom);
          in_valid = 1'($urandom_range(0, 1));
          for (int k = 1; k <= int'(dly); k++) begin
            n_cmp++; if (in_ready !== 1'b0 || wb_stall !== 1'b1 || rf_we !== 1'b0) begin n_bad++; $display("FAIL rnd_wait got %0h/%0h/%0h want 0/1/0", in_ready, wb_stall, rf_we); end
            mem_rsp_valid = (k == int'(dly)); mem_rsp_data = dat;
            tick();
          end
        end
        drive_idle();
        m_cnt++;
        xwe = we && rd != 0 && !ld_bad(f3, a);
        xerr = we && rd != 0 && ld_bad(f3, a);
        if (xwe) begin
          m_waddr = rd;
          m_wdata = ld_val(dat, f3, a);
        end
      end else begin
        drive_idle();
        mem_rsp_valid = 1; mem_rsp_data = $urandom;
        tick();
        mem_rsp_valid = 0;
        xwe = 1'b0; xerr = 1'b0;
      end
      n_cmp++; if (rf_we !== xwe || misalign_err !== xerr) begin n_bad++; $display("FAIL rnd%0d_we_err got %0h/%0h want %0h/%0h", i, rf_we, misalign_err, xwe, xerr); end
      n_cmp++; if (rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin n_bad++; $display("FAIL rnd%0d_data got %0d/%0h want %0d/%0h", i, rf_waddr, rf_wdata, m_waddr, m_wdata); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_ready got %0h want 1", i, in_ready); end
`ifdef WB_RETIRE_CNT_EN
      n_cmp++; if (retire_count !== m_cnt) begin n_bad++; $display("FAIL rnd%0d_retire got %0d want %0d", i, retire_count, m_cnt); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_jal();
    test_reserved();
    test_delayed_lb();
    test_same_cycle();
    test_misalign();
`ifdef WB_RETIRE_CNT_EN
    n_cmp++; if (retire_count !== m_cnt) begin n_bad++; $display("FAIL retire_directed got %0d want %0d", retire_count, m_cnt); end
`endif
    test_reset_wait();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the rv32 pipeline; consumer of the 2-bit wb_sel produced by the control unit.
- Selects the writeback source (load data, ALU result or PC+4).
- Sign/zero-extends and aligns load data, waits on a variable-latency data-memory response, and drives the register-file write port.
- Stalls the upstream pipeline while a load response is outstanding.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  instruction presented to writeback
- in_ready  output  1  stage can accept; low while a load is pending
- in_wb_sel  input  2  00 = memory, 01 = ALU, 10 = PC+4, 11 = reserved
- in_rd_we  input  1  instruction writes rd (0 for store, branch, fence, system)
- in_rd  input  5  destination register
- in_is_load  input  1  instruction is a load (valid only with wb_sel = 00)
- in_funct3  input  3  load size/sign
- in_addr_lo  input  2  load byte address [1:0]
- in_alu_result  input  32  ALU result
- in_pc_plus4  input  32  return address for JAL/JALR
- mem_rsp_valid  input  1  data-memory read response valid (single-cycle pulse)
- mem_rsp_data  input  32  aligned word read from memory
- rf_we  output  1  register-file write enable
- rf_waddr  output  5  register-file write address
- rf_wdata  output  32  register-file write data
- wb_stall  output  1  upstream stall request
- misalign_err  output  1  one-cycle pulse on a misaligned or illegal load

Behaviour:
- Reset (async): state = IDLE; rf_we = 0; rf_waddr = 0; rf_wdata = 0; misalign_err = 0; all pending-load capture registers = 0.
- in_ready = (state == IDLE).
- wb_stall = (state == WAIT_LOAD), or (in_valid & in_is_load & !mem_rsp_valid) in IDLE. The second term is combinational.
- Accept = in_valid & in_ready.

State IDLE:
- On accept with in_is_load = 0: registered write on the next clk edge.
  - rf_we = in_rd_we & (in_rd != 0) & (in_wb_sel != 11).
  - rf_wdata = ALU result for 01, pc_plus4 for 10, 0 for 00 or 11.
  - Latency: 1 cycle.
- On accept with in_is_load = 1 and mem_rsp_valid = 1 in the same cycle: complete immediately, as in the load-completion rule; stay in IDLE.
- On accept with in_is_load = 1 and mem_rsp_valid = 0: capture rd, rd_we, funct3 and addr_lo; go to WAIT_LOAD.
- mem_rsp_valid with no load accepted: ignored, no write.

State WAIT_LOAD:
- in_valid is ignored; the upstream stage holds the instruction.
- On mem_rsp_valid: perform load completion and return to IDLE. The next instruction can be accepted in the following cycle.

Load completion (registered, one edge after the response):
- Byte select: mem_rsp_data >> (8 * addr_lo).
- funct3 000 LB: sign-extend bits [7:0].
- funct3 100 LBU: zero-extend bits [7:0].
- funct3 001 LH: sign-extend bits [15:0].
- funct3 101 LHU: zero-extend bits [15:0].
- funct3 010 LW: full word.
- Misaligned loads: halfword with addr_lo[0] = 1, or word with addr_lo != 0. rf_we = 0 and misalign_err pulses for 1 cycle.
- Illegal funct3 (011, 110, 111): same handling as misaligned.
- rd == 0 or rd_we == 0: rf_we = 0 and no error.

Output hold and edge cases:
- Outside write cycles, rf_we is 0 and rf_waddr/rf_wdata hold their last values.
- Reset asserted mid-WAIT_LOAD: the pending load is dropped, with no write and no error. A late mem_rsp_valid after reset is ignored.
- Back-to-back non-load accepts produce one write per cycle.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- When defined:
  - Adds output retire_count [63:0], reset to 0.
  - Increments by 1 on every instruction completion: each non-load accept, and each load completion including suppressed or misaligned ones.
  - Wraps 2^64-1 -> 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- ALU writeback: accept wb_sel = 01, rd = 5, we = 1, alu = 0x1234_5678 -> next cycle rf_we = 1, waddr = 5, wdata = 0x1234_5678; in_ready stays 1.
- JAL writeback: wb_sel = 10, rd = 1, pc_plus4 = 0x0000_0104 -> rf_we = 1, wdata = 0x0000_0104. Same with rd = 0 -> rf_we = 0.
- Delayed LB: accept funct3 = 000, addr_lo = 2, rd = 7, no rsp.
  - Expect in_ready = 0, wb_stall = 1 for 3 cycles.
  - Then rsp 0x00F0_0000 -> next cycle wdata = 0xFFFF_FFF0, waddr = 7.
  - Then IDLE.
- Same-cycle LHU and LW:
  - LHU, addr_lo = 2, rsp 0xBEEF_0000 arriving with the accept -> wdata = 0x0000_BEEF, no stall cycle.
  - LW, addr_lo = 0, rsp 0xDEAD_BEEF -> wdata = 0xDEAD_BEEF.
- Misaligned: LW addr_lo = 1, rsp arrives -> rf_we = 0, misalign_err = 1 for exactly 1 cycle.
- Reset in WAIT_LOAD and reserved wb_sel:
  - Assert rst while waiting, then rsp -> no write, state IDLE.
  - wb_sel = 11 with we = 1 -> rf_we = 0.
  - With WB_RETIRE_CNT_EN: retire_count increments once per completed instruction.
